instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Writer side of the instruction memory: accepts a stream of INSTR_W-bit words and writes them
//  into the instruction RAM at consecutive addresses, from load_base.
//  Re-reads the written range through the memory's async read port and checks a running sum.
//  On a match, pulses start/start_address into IF so fetch begins at load_base.
//  Sits between the host/test stream and the InstrROM write port + IF start inputs.
// PARAMETERS
//  ADDR_W   8   instruction address width (matches IF PC)
//  INSTR_W  9   instruction word width (matches instruction_out)
//  LEN_W    9   word-count width (ADDR_W+1, allows full 256-word load)
// PORTS
//  CLK            in   1        clock, all state on rising edge
//  reset_n        in   1        synchronous active-low reset
//  load_req       in   1        request a load; sampled only in IDLE
//  load_base      in   ADDR_W   first write address, captured with load_req
//  load_len       in   LEN_W    word count, captured with load_req
//  in_valid       in   1        stream word valid
//  in_data        in   INSTR_W  stream word
//  in_ready       out  1        loader accepts in_data this cycle
//  wr_en          out  1        memory write strobe
//  wr_addr        out  ADDR_W   memory write address
//  wr_data        out  INSTR_W  memory write data
//  rd_addr        out  ADDR_W   memory read address (combinational read, data same cycle)
//  rd_data        in   INSTR_W  memory read data
//  start          out  1        one-cycle pulse to IF
//  start_address  out  ADDR_W   held = captured load_base once launched
//  busy           out  1        high in LOAD/VERIFY/LAUNCH
//  done           out  1        sticky: load verified and launched
//  error          out  1        sticky: empty load or checksum mismatch
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE; in_ready, wr_en, start, busy, done, error = 0.
//  Reset also clears wr_addr, wr_data, rd_addr, start_address, counters and sum to 0.
//  Reset mid-load aborts immediately; no further wr_en. Partial memory contents are left as-is.
//  States: IDLE -> LOAD -> VERIFY -> LAUNCH -> IDLE; IDLE -> IDLE(error) for len 0.
//  IDLE: load_req=1 captures base/len; clears done, error, sum and counters.
//   len=0 -> error=1, stay IDLE. Otherwise -> LOAD.
//  LOAD: in_ready=1 (combinational from state).
//   Handshake in_valid&&in_ready: wr_en=1 same cycle, wr_addr=base+idx, wr_data=in_data.
//   Same handshake: sum+=in_data mod 2^INSTR_W, idx++.
//   in_valid=0 stalls with no write. After the len-th write (same edge) -> VERIFY, idx=0.
//  VERIFY: in_ready=0, rd_addr=base+idx, one word per cycle; vsum+=rd_data. len cycles total.
//   Final edge compares vsum to sum: equal -> LAUNCH; unequal -> error=1, IDLE, no start.
//  LAUNCH: start=1 for exactly one cycle; start_address=base; done=1; -> IDLE.
//  Address arithmetic is modulo 2^ADDR_W: base=250, len=10 writes 250..255 then 0..3.
//  load_req while busy is ignored. in_valid outside LOAD is ignored, no write.
//  Throughput: 1 word/cycle. Latency from last accepted word to start pulse = len+1 cycles.
// STRUCTURE
//  Shared package loader_pkg: loader_state_e {IDLE,LOAD,VERIFY,LAUNCH};
//   ADDR_W/INSTR_W defaults as localparams shared with IF/InstrROM.
//  One sub-module: loader_cksum (clear, add_en, din, sum).
//   Instantiated twice: write sum, verify sum.
// TESTING
//  1. base=0,len=4, words 1,2,3,4 back-to-back:
//     writes addr 0..3; start pulses once, start_address=0; done=1.
//  2. Same load with in_valid toggling every other cycle:
//     exactly 4 wr_en pulses, data order preserved, done=1.
//  3. base=254,len=4:
//     wr_addr 254,255,0,1; verify rd_addr same sequence; start_address=254.
//  4. Bench corrupts addr 2 between LOAD and VERIFY (sum off):
//     error=1, start never pulses, done=0.
//  5. load_req with len=0 -> error=1 next cycle, no wr_en.
//     load_req during LOAD -> ignored, capture unchanged.
//  6. reset_n=0 after 2 of 4 words:
//     next cycle IDLE, all outputs 0; fresh load then completes normally.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared widths and state encoding for the instruction loader
package loader_pkg;

    // Defaults shared with IF (PC width) and InstrROM (word width).
    localparam int IMEM_ADDR_W  = 8;
    localparam int IMEM_INSTR_W = 9;
    localparam int IMEM_LEN_W   = IMEM_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        LAUNCH = 2'd3
    } loader_state_e;

endpackage

// File: rtl/loader_cksum.sv
// rtl/loader_cksum.sv - modulo-2^W running sum accumulator
//
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset, clears sum
//   clear    clears sum (priority over add_en)
//   add_en   adds din into sum this edge
//   din      addend
//   sum      registered running sum, wraps modulo 2^W
module loader_cksum #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         add_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams words into instruction RAM, verifies by read-back sum, launches fetch
//
// Ports:
//   CLK, reset_n                       clock, synchronous active-low reset
//   load_req, load_base, load_len      load request with base address and word count (IDLE only)
//   in_valid, in_data, in_ready        input word stream
//   wr_en, wr_addr, wr_data            instruction RAM write port
//   rd_addr, rd_data                   instruction RAM async read port
//   start, start_address               one-cycle launch pulse and held launch address to IF
//   busy, done, error                  status: in progress, sticky success, sticky failure
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W  = IMEM_ADDR_W,
    parameter int INSTR_W = IMEM_INSTR_W,
    parameter int LEN_W   = ADDR_W + 1
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               load_req,
    input  logic [ADDR_W-1:0]  load_base,
    input  logic [LEN_W-1:0]   load_len,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [INSTR_W-1:0] rd_data,
    output logic               start,
    output logic [ADDR_W-1:0]  start_address,
    output logic               busy,
    output logic               done,
    output logic               error
);

    loader_state_e      state;
    logic [ADDR_W-1:0]  base;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   idx;
    logic [INSTR_W-1:0] write_sum;
    logic [INSTR_W-1:0] verify_sum;
    logic [INSTR_W-1:0] verify_sum_next;
    logic               handshake;
    logic               load_accept;
    logic               last_idx;
    logic [ADDR_W-1:0]  cur_addr;

    assign in_ready    = (state == LOAD);
    assign handshake   = in_valid && in_ready;
    assign load_accept = (state == IDLE) && load_req;
    assign last_idx    = (idx == len - LEN_W'(1));
    // Truncation gives the modulo-2^ADDR_W wrap of the write/read window.
    assign cur_addr    = base + idx[ADDR_W-1:0];

    assign wr_en   = handshake;
    assign wr_addr = cur_addr;
    assign wr_data = handshake ? in_data : '0;
    assign rd_addr = (state == VERIFY) ? cur_addr : '0;

    // The final verify edge must include the word being read this cycle,
    // so the comparison uses the sum as it will be after this add.
    assign verify_sum_next = verify_sum + rd_data;

    loader_cksum #(.W(INSTR_W)) u_write_sum (
        .clk     (CLK),
        .reset_n (reset_n),
        .clear   (load_accept),
        .add_en  (handshake),
        .din     (in_data),
        .sum     (write_sum)
    );

    loader_cksum #(.W(INSTR_W)) u_verify_sum (
        .clk     (CLK),
        .reset_n (reset_n),
        .clear   (load_accept),
        .add_en  (state == VERIFY),
        .din     (rd_data),
        .sum     (verify_sum)
    );

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state         <= IDLE;
            base          <= '0;
            len           <= '0;
            idx           <= '0;
            start         <= 1'b0;
            start_address <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_req) begin
                        base  <= load_base;
                        len   <= load_len;
                        idx   <= '0;
                        done  <= 1'b0;
                        if (load_len == '0) begin
                            error <= 1'b1;
                        end else begin
                            error <= 1'b0;
                            busy  <= 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        if (last_idx) begin
                            idx   <= '0;
                            state <= VERIFY;
                        end else begin
                            idx <= idx + LEN_W'(1);
                        end
                    end
                end
                VERIFY: begin
                    if (last_idx) begin
                        idx <= '0;
                        if (verify_sum_next == write_sum) begin
                            start         <= 1'b1;
                            start_address <= base;
                            done          <= 1'b1;
                            state         <= LAUNCH;
                        end else begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        idx <= idx + LEN_W'(1);
                    end
                end
                LAUNCH: begin
                    start <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic       load_req;
    logic [7:0] load_base;
    logic [8:0] load_len;
    logic       in_valid;
    logic [8:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [8:0] wr_data;
    logic [7:0] rd_addr;
    logic [8:0] rd_data;
    logic       start;
    logic [7:0] start_address;
    logic       busy;
    logic       done;
    logic       error;

    always #5 CLK = ~CLK;

    instr_loader dut (
        .CLK           (CLK),
        .reset_n       (reset_n),
        .load_req      (load_req),
        .load_base     (load_base),
        .load_len      (load_len),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .start         (start),
        .start_address (start_address),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    // Instruction RAM: sync write, async read, optional one-bit corruption.
    logic [8:0] mem [256];
    logic       corrupt = 1'b0;
    logic [7:0] corrupt_addr = 8'd0;

    always @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        else if (corrupt) mem[corrupt_addr] <= mem[corrupt_addr] ^ 9'h001;
    end
    assign rd_data = mem[rd_addr];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: every load is a list of (address, word) writes at (base+i) mod 256,
    // followed by reads of the same addresses, then at most one start pulse.
    logic [7:0] exp_wa [$];
    logic [8:0] exp_wd [$];
    logic [7:0] exp_ra [$];
    int         wr_cnt, start_cnt, last_hs_cyc, start_cyc;
    logic [7:0] last_start_addr;
    logic [7:0] ea;
    logic [8:0] ed;
    int         words [$];

    always @(negedge CLK) begin
        if (reset_n) begin
            chk("wr_en_vs_handshake", int'(wr_en), int'(in_valid && in_ready));
            chk("ready_outside_busy", int'(in_ready && !busy), 0);
            if (wr_en) begin
                wr_cnt++;
                last_hs_cyc = cyc;
                if (exp_wa.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    ea = exp_wa.pop_front();
                    ed = exp_wd.pop_front();
                    chk("wr_addr", int'(wr_addr), int'(ea));
                    chk("wr_data", int'(wr_data), int'(ed));
                end
            end
            if (busy && !in_ready && !start) begin
                if (exp_ra.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    ea = exp_ra.pop_front();
                    chk("rd_addr", int'(rd_addr), int'(ea));
                end
            end
            if (start) begin
                start_cnt++;
                start_cyc       = cyc;
                last_start_addr = start_address;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mid_req: re-assert load_req with different parameters during word 1.
    task automatic run_load(input int base, input int len, input bit gap,
                            input bit corrupt2, input bit mid_req);
        int n;
        wr_cnt    = 0;
        start_cnt = 0;
        for (int i = 0; i < len; i++) begin
            exp_wa.push_back(8'((base + i) % 256));
            exp_wd.push_back(9'(words[i]));
            exp_ra.push_back(8'((base + i) % 256));
        end
        load_req  = 1'b1;
        load_base = 8'(base);
        load_len  = 9'(len);
        tick();
        load_req = 1'b0;
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = 9'(words[i]);
            if (mid_req && i == 1) begin
                load_req  = 1'b1;
                load_base = 8'd99;
                load_len  = 9'd7;
            end
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) chk("handshake_timeout", n, 0);
            tick();
            load_req = 1'b0;
            in_valid = 1'b0;
            if (gap) tick();
        end
        if (corrupt2) begin
            corrupt      = 1'b1;
            corrupt_addr = 8'd2;
            tick();
            corrupt = 1'b0;
        end
        n = 0;
        while (!(done || error) && n < len + 20) begin
            tick();
            n++;
        end
        if (n >= len + 20) chk("completion_timeout", n, 0);
        repeat (3) tick();
        chk("queues_drained", exp_wa.size() + exp_ra.size(), 0);
        chk("idle_after_load", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        load_req  = 1'b0;
        load_base = 8'd0;
        load_len  = 9'd0;
        in_valid  = 1'b0;
        in_data   = 9'd0;
        repeat (2) tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_start_address", int'(start_address), 0);
        reset_n = 1'b1;
        tick();

        // 1: base 0, words 1..4 back-to-back
        words = '{1, 2, 3, 4};
        run_load(0, 4, 1'b0, 1'b0, 1'b0);
        chk("t1_wr_cnt", wr_cnt, 4);
        chk("t1_start_cnt", start_cnt, 1);
        chk("t1_start_address", int'(last_start_addr), 0);
        chk("t1_done", int'(done), 1);
        chk("t1_error", int'(error), 0);
        chk("t1_latency", start_cyc - last_hs_cyc, 5);
        chk("t1_mem0", int'(mem[0]), 1);
        chk("t1_mem3", int'(mem[3]), 4);

        // 2: same load with idle cycles between words
        words = '{1, 2, 3, 4};
        run_load(0, 4, 1'b1, 1'b0, 1'b0);
        chk("t2_wr_cnt", wr_cnt, 4);
        chk("t2_start_cnt", start_cnt, 1);
        chk("t2_done", int'(done), 1);

        // 3: wrap around the top of the address space
        words = '{511, 5, 256, 7};
        run_load(254, 4, 1'b0, 1'b0, 1'b0);
        chk("t3_start_address", int'(last_start_addr), 254);
        chk("t3_start_cnt", start_cnt, 1);
        chk("t3_mem254", int'(mem[254]), 511);
        chk("t3_mem1", int'(mem[1]), 7);
        chk("t3_latency", start_cyc - last_hs_cyc, 5);

        // 4: corrupt addr 2 before it is read back
        words = '{10, 20, 30, 40};
        run_load(0, 4, 1'b0, 1'b1, 1'b0);
        chk("t4_error", int'(error), 1);
        chk("t4_done", int'(done), 0);
        chk("t4_start_cnt", start_cnt, 0);

        // 5a: zero-length load, stray in_valid while idle
        wr_cnt    = 0;
        start_cnt = 0;
        load_req  = 1'b1;
        load_base = 8'd5;
        load_len  = 9'd0;
        in_valid  = 1'b1;
        in_data   = 9'd77;
        tick();
        load_req = 1'b0;
        chk("t5_error_next", int'(error), 1);
        chk("t5_busy", int'(busy), 0);
        repeat (3) tick();
        in_valid = 1'b0;
        chk("t5_wr_cnt", wr_cnt, 0);
        chk("t5_start_cnt", start_cnt, 0);

        // 5b: load_req during LOAD is ignored
        words = '{100, 200, 300};
        run_load(10, 3, 1'b0, 1'b0, 1'b1);
        chk("t5b_wr_cnt", wr_cnt, 3);
        chk("t5b_start_address", int'(last_start_addr), 10);
        chk("t5b_done", int'(done), 1);
        chk("t5b_error", int'(error), 0);

        // 6: reset after two of four words
        wr_cnt    = 0;
        start_cnt = 0;
        exp_wa.push_back(8'd40); exp_wd.push_back(9'd11);
        exp_wa.push_back(8'd41); exp_wd.push_back(9'd12);
        load_req  = 1'b1;
        load_base = 8'd40;
        load_len  = 9'd4;
        tick();
        load_req = 1'b0;
        in_valid = 1'b1;
        in_data  = 9'd11;
        tick();
        in_data  = 9'd12;
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_in_ready", int'(in_ready), 0);
        chk("t6_wr_en", int'(wr_en), 0);
        chk("t6_start", int'(start), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_error", int'(error), 0);
        chk("t6_wr_addr", int'(wr_addr), 0);
        chk("t6_wr_data", int'(wr_data), 0);
        chk("t6_rd_addr", int'(rd_addr), 0);
        chk("t6_start_address", int'(start_address), 0);
        in_valid = 1'b1;
        in_data  = 9'd85;
        repeat (2) tick();
        in_valid = 1'b0;
        chk("t6_wr_cnt", wr_cnt, 2);
        words = '{3, 6, 9, 12};
        run_load(100, 4, 1'b0, 1'b0, 1'b0);
        chk("t6_fresh_done", int'(done), 1);
        chk("t6_fresh_start_address", int'(last_start_addr), 100);
        chk("t6_fresh_start_cnt", start_cnt, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
